// File: rtl/s_dly_meas.sv
// Latency meter: measures cycles from a start pulse to its returned echo,
// flags timeouts and tracks the largest delay observed.
module s_dly_meas #(
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             echo,
   input  logic             clr_max,
   output logic             busy,
   output logic             meas_done,
   output logic [CNT_W-1:0] meas_val,
   output logic             timeout,
   output logic [CNT_W-1:0] meas_max
);

   if (TIMEOUT < 1 ||
       longint'(TIMEOUT) > (longint'(1) << CNT_W) - 1) begin : g_bad_timeout
      $error("s_dly_meas: TIMEOUT out of range for CNT_W");
   end

   localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             to_q;
   logic [CNT_W-1:0] val_q;
   logic [CNT_W-1:0] max_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         to_q    <= 1'b0;
         val_q   <= '0;
         max_q   <= '0;
      end else begin
         done_q <= 1'b0;
         to_q   <= 1'b0;
         if (clr_max) begin
            max_q <= '0;
         end
         unique case (state_q)
            IDLE: begin
               if (start && echo) begin
                  // zero-delay: max(meas_max, 0) leaves meas_max as is
                  done_q <= 1'b1;
                  val_q  <= '0;
               end else if (start) begin
                  state_q <= RUN;
                  busy_q  <= 1'b1;
                  cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            RUN: begin
               if (echo) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  val_q   <= cnt_q;
                  if (!clr_max && cnt_q > max_q) begin
                     max_q <= cnt_q;
                  end
               end else if (cnt_q == TMO_C) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  to_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign meas_done = done_q;
   assign timeout   = to_q;
   assign meas_val  = val_q;
   assign meas_max  = max_q;

endmodule

// File: tb/tb_s_dly_meas.sv
// Bench for s_dly_meas: directed vector table, hand sequences and
// random traffic against a timestamp-based reference model.
module tb_s_dly_meas;

   localparam int CW  = 8;
   localparam int TMO = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          echo = 1'b0;
   logic          clr_max = 1'b0;
   logic          busy;
   logic          meas_done;
   logic [CW-1:0] meas_val;
   logic          timeout;
   logic [CW-1:0] meas_max;

   s_dly_meas #(.CNT_W(CW), .TIMEOUT(TMO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .echo      (echo),
      .clr_max   (clr_max),
      .busy      (busy),
      .meas_done (meas_done),
      .meas_val  (meas_val),
      .timeout   (timeout),
      .meas_max  (meas_max)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic          s, e, c;
      logic          b, d, t;
      logic [CW-1:0] v, m;
   } vec_t;

   vec_t tbl[$];

   // model: measurement = difference of edge indices
   int            cyc    = 0;
   int            pend   = -1;
   logic          m_busy = 0;
   logic          m_done = 0;
   logic          m_to   = 0;
   int            m_val  = 0;
   int            m_max  = 0;

   function automatic void push(logic s, logic e, logic c, logic b,
                                logic d, logic t, int v, int m, int n);
      for (int i = 0; i < n; i++)
         tbl.push_back('{s, e, c, b, d, t, CW'(v), CW'(m)});
   endfunction

   function automatic void model_reset();
      pend = -1; m_busy = 0; m_done = 0; m_to = 0; m_val = 0; m_max = 0;
   endfunction

   function automatic void model_edge(logic s, logic e, logic c);
      int d;
      m_done = 0;
      m_to   = 0;
      if (pend < 0) begin
         if (s && e) begin
            m_done = 1; m_val = 0;
         end else if (s) begin
            pend = cyc;
         end
      end else begin
         d = cyc - pend;
         if (e) begin
            m_done = 1; m_val = d; pend = -1;
            if (d > m_max) m_max = d;
         end else if (d == TMO) begin
            m_to = 1; pend = -1;
         end
      end
      if (c) m_max = 0;
      m_busy = (pend >= 0);
      cyc++;
   endfunction

   function automatic logic [2*CW+2:0] dut_vec();
      return {busy, meas_done, timeout, meas_val, meas_max};
   endfunction

   function automatic logic [2*CW+2:0] mdl_vec();
      return {m_busy, m_done, m_to, CW'(m_val), CW'(m_max)};
   endfunction

   task automatic chk(input string nm, input logic [2*CW+2:0] act,
                      input logic [2*CW+2:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s t=%0t got b/d/t/val/max=%h want=%h",
                  nm, $time, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic e, input logic c);
      start = s; echo = e; clr_max = c;
      model_edge(s, e, c);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic step_chk(input string nm, input logic s, input logic e,
                           input logic c);
      step(s, e, c);
      chk(nm, dut_vec(), mdl_vec());
   endtask

   initial begin
      // delay 3
      push(1,0,0, 1,0,0, 0,0, 1);
      push(0,0,0, 1,0,0, 0,0, 2);
      push(0,1,0, 0,1,0, 3,3, 1);
      // zero delay, then delay 1
      push(1,1,0, 0,1,0, 0,3, 1);
      push(1,0,0, 1,0,0, 0,3, 1);
      push(0,1,0, 0,1,0, 1,3, 1);
      // delay 5 with starts ignored while running
      push(1,0,0, 1,0,0, 1,3, 1);
      push(1,0,0, 1,0,0, 1,3, 2);
      push(0,0,0, 1,0,0, 1,3, 2);
      push(0,1,0, 0,1,0, 5,5, 1);
      // start in the meas_done cycle, then held echo
      push(1,0,0, 1,0,0, 5,5, 1);
      push(0,1,0, 0,1,0, 1,5, 1);
      push(0,1,0, 0,0,0, 1,5, 1);
      // timeout, late echo ignored
      push(1,0,0, 1,0,0, 1,5, 1);
      push(0,0,0, 1,0,0, 1,5, 9);
      push(0,0,0, 0,0,1, 1,5, 1);
      push(0,0,0, 0,0,0, 1,5, 1);
      push(0,1,0, 0,0,0, 1,5, 1);
      // delay exactly TIMEOUT
      push(1,0,0, 1,0,0, 1,5, 1);
      push(0,0,0, 1,0,0, 1,5, 9);
      push(0,1,0, 0,1,0, 10,10, 1);
      // max tracking 4,7,2 then 9 with clr_max
      push(0,0,1, 0,0,0, 10,0, 1);
      push(1,0,0, 1,0,0, 10,0, 1);
      push(0,0,0, 1,0,0, 10,0, 3);
      push(0,1,0, 0,1,0, 4,4, 1);
      push(1,0,0, 1,0,0, 4,4, 1);
      push(0,0,0, 1,0,0, 4,4, 6);
      push(0,1,0, 0,1,0, 7,7, 1);
      push(1,0,0, 1,0,0, 7,7, 1);
      push(0,0,0, 1,0,0, 7,7, 1);
      push(0,1,0, 0,1,0, 2,7, 1);
      push(1,0,0, 1,0,0, 2,7, 1);
      push(0,0,0, 1,0,0, 2,7, 8);
      push(0,1,1, 0,1,0, 9,0, 1);

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset", dut_vec(), '0);
      rst_n = 1'b1;
      model_reset();

      foreach (tbl[i]) begin
         step(tbl[i].s, tbl[i].e, tbl[i].c);
         chk($sformatf("vec%0d", i), dut_vec(),
             {tbl[i].b, tbl[i].d, tbl[i].t, tbl[i].v, tbl[i].m});
      end

      for (int i = 0; i < 3000; i++) begin
         step_chk("rand",
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 63) == 0);
      end

      // reset mid-run of a delay-6 measurement
      repeat (TMO + 2) step_chk("drain", 1'b0, 1'b0, 1'b0);
      step_chk("r6_t0", 1'b1, 1'b0, 1'b0);
      step_chk("r6_t1", 1'b0, 1'b0, 1'b0);
      step_chk("r6_t2", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid", dut_vec(), '0);
      model_reset();
      @(negedge clk);
      chk("rst_hold", dut_vec(), '0);
      rst_n = 1'b1;
      step_chk("r6b_t0", 1'b1, 1'b0, 1'b0);
      repeat (5) step_chk("r6b_run", 1'b0, 1'b0, 1'b0);
      step_chk("r6b_end", 1'b0, 1'b1, 1'b0);
      chk("r6b_val", dut_vec(), {1'b0, 1'b1, 1'b0, 8'd6, 8'd6});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/s_dly_meas.md
Name: s_dly_meas

Overview:
- Latency meter for fixed-delay paths: the receiving end of a delayed-pulse path.
- Issues nothing itself. Observes a launch pulse (start) and the pulse that returns after an n-clock pipeline or delay chain (echo).
- Reports the measured delay in clock cycles, flags timeouts, and tracks the maximum delay seen.
- Used in-system and in benches to check that delay chains built from s_dff_nclk instances deliver exactly their configured DELAY.

Parameters:
- CNT_W, 8: width of the cycle counter and of meas_val and meas_max.
- TIMEOUT, 255: largest measurable delay in cycles. Must satisfy 1 <= TIMEOUT <= 2^CNT_W-1; otherwise elaboration fails.

Ports:
- clk  input  1  system clock; rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch pulse; sampled each cycle.
- echo  input  1  returned pulse; sampled each cycle.
- clr_max  input  1  synchronous clear of meas_max.
- busy  output  1  high while a measurement is in progress (state RUN).
- meas_done  output  1  one-cycle pulse when a measurement completes.
- meas_val  output  CNT_W  last measured delay; held until the next completion.
- timeout  output  1  one-cycle pulse when a measurement is abandoned.
- meas_max  output  CNT_W  largest meas_val since reset or clr_max.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, counter 0, busy 0, meas_done 0, timeout 0, meas_val 0, meas_max 0. All outputs are registered.
- Delay definition: start sampled high at edge t and echo first sampled high at edge t+N gives meas_val = N. A chain of DELAY flops gives N = DELAY.
- FSM has two states, IDLE and RUN.
- IDLE:
  - start=1 and echo=1 in the same cycle: zero-delay case. Stay in IDLE; next cycle meas_done=1 and meas_val=0.
  - start=1 and echo=0: go to RUN, counter <= 1.
  - echo with no start: ignored.
- RUN:
  - echo=1: meas_val <= counter, go to IDLE; meas_done=1 in the following cycle.
  - echo=0 and counter == TIMEOUT: go to IDLE; timeout=1 in the following cycle; meas_val unchanged.
  - Otherwise: counter <= counter+1.
  - start is ignored while in RUN. There is no re-launch and no queuing.
- Timing boundaries:
  - meas_done and timeout assert exactly one cycle after the deciding edge.
  - A start sampled in that same cycle (the meas_done or timeout cycle) is accepted; back-to-back measurements are legal.
  - A delay of exactly TIMEOUT is measured. A delay of TIMEOUT+1 or more gives timeout; the late echo is then ignored while in IDLE.
- meas_done and timeout are mutually exclusive.
- The counter never wraps, because TIMEOUT <= 2^CNT_W-1.
- busy = (state == RUN). It is registered and aligned with the state.
- meas_max:
  - Updated in the same cycle as meas_val: meas_max <= max(meas_max, new value). Timeouts do not update it.
  - clr_max=1 sets meas_max to 0. If a completion occurs in the same cycle, clr_max wins and the new value is not applied to meas_max; meas_val still updates.
- echo held high for several cycles: only the first sample in RUN counts. Next cycle state is IDLE and echo is ignored.
- Reset asserted mid-RUN aborts immediately: no meas_done or timeout pulse, and all registers return to reset values.
- start and echo are synchronous to clk. No internal synchronizers.

Test Plan:
- Chain of s_dff_nclk with DELAY=3: start pulse at edge t -> meas_done at t+4, meas_val=3, busy high for edges t+1..t+3, meas_max=3.
- Zero delay, start and echo in the same cycle -> meas_done next cycle, meas_val=0, busy never asserts. Then DELAY=1 -> meas_val=1.
- TIMEOUT=10, no echo -> timeout pulse at t+11, meas_val retains previous value. An echo at t+12 is ignored. A separate run with delay exactly 10 -> meas_val=10, no timeout.
- Second start at t+1 and t+2 during RUN with DELAY=5 -> single meas_done, meas_val=5. A new start in the meas_done cycle -> second measurement accepted.
- Sequence of delays 4, 7, 2 -> meas_max goes 4, 7, 7. clr_max together with a completion of 9 -> meas_max=0, meas_val=9.
- rst_n low at t+2 of a DELAY=6 run -> outputs zero at once, no meas_done. After release, a new DELAY=6 run -> meas_val=6.
